// File: rtl/chacha_block_seq.sv
// rtl/chacha_block_seq.sv - iterative ChaCha block function, one double-half round per cycle
//
// Computes one 512-bit ChaCha keystream block from a 256-bit key, 32-bit block
// counter and 96-bit nonce. One column or diagonal round (four parallel
// quarter rounds) is applied per ROUND cycle, so a block takes ROUNDS+1 edges
// from acceptance to out_valid.
//
// Parameters:
//   ROUNDS     total ChaCha rounds (even, 2..30; 8/12/20 are the usual variants)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request offered (key/blk_ctr/nonce valid)
//   in_ready   idle and able to accept; request accepted when both are high
//   key        256-bit key, word i = key[32i+31:32i]
//   blk_ctr    block counter (state word 12)
//   nonce      96-bit nonce, word j maps to state word 13+j
//   out_valid  keystream block available
//   out_ready  consumer accepts the block (ignored while out_valid = 0)
//   out_block  512-bit keystream, word i = out_block[32i+31:32i]
//   busy       high in any state other than IDLE
//
// Build option:
//   CHACHA_ZEROIZE_EN  when defined, working state, initial state and
//                      out_block are cleared on the output handshake edge.

module chacha_block_seq #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [31:0]  blk_ctr,
  input  logic [95:0]  nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  state_t      state;
  logic [4:0]  round_cnt;
  logic [31:0] work   [16];
  logic [31:0] init_s [16];
  logic [31:0] nxt    [16];

  // ChaCha quarter round; result packed as {a, b, c, d}.
  function automatic logic [127:0] quarter_round(
    input logic [31:0] a_in,
    input logic [31:0] b_in,
    input logic [31:0] c_in,
    input logic [31:0] d_in
  );
    logic [31:0] a, b, c, d;
    a = a_in;
    b = b_in;
    c = c_in;
    d = d_in;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // One round of the working state. Even round_cnt selects the column round,
  // odd selects the diagonal round: quarter round q touches words
  // q, 4+(q+s)%4, 8+(q+2s)%4, 12+(q+3s)%4 with s = 0 (column) or 1 (diagonal).
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      nxt[i] = work[i];
    end
    for (int q = 0; q < 4; q++) begin
      logic [3:0] ia, ib, ic, id;
      if (round_cnt[0]) begin
        ia = 4'(q);
        ib = 4'(4  + ((q + 1) % 4));
        ic = 4'(8  + ((q + 2) % 4));
        id = 4'(12 + ((q + 3) % 4));
      end else begin
        ia = 4'(q);
        ib = 4'(4  + q);
        ic = 4'(8  + q);
        id = 4'(12 + q);
      end
      {nxt[ia], nxt[ib], nxt[ic], nxt[id]} =
        quarter_round(work[ia], work[ib], work[ic], work[id]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_cnt <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_block <= '0;
      for (int i = 0; i < 16; i++) begin
        work[i]   <= '0;
        init_s[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // in_ready is a register so it reads 0 during reset and rises on
          // the first edge afterwards.
          if (in_valid && in_ready) begin
            work[0]   <= SIGMA0;
            work[1]   <= SIGMA1;
            work[2]   <= SIGMA2;
            work[3]   <= SIGMA3;
            init_s[0] <= SIGMA0;
            init_s[1] <= SIGMA1;
            init_s[2] <= SIGMA2;
            init_s[3] <= SIGMA3;
            for (int i = 0; i < 8; i++) begin
              work[4 + i]   <= key[32*i +: 32];
              init_s[4 + i] <= key[32*i +: 32];
            end
            work[12]   <= blk_ctr;
            init_s[12] <= blk_ctr;
            for (int j = 0; j < 3; j++) begin
              work[13 + j]   <= nonce[32*j +: 32];
              init_s[13 + j] <= nonce[32*j +: 32];
            end
            round_cnt <= '0;
            in_ready  <= 1'b0;
            state     <= ROUND;
          end else begin
            in_ready <= 1'b1;
          end
        end

        ROUND: begin
          for (int i = 0; i < 16; i++) begin
            work[i] <= nxt[i];
          end
          round_cnt <= round_cnt + 5'd1;
          if (round_cnt == LAST_ROUND) begin
            state <= FINAL;
          end
        end

        FINAL: begin
          for (int i = 0; i < 16; i++) begin
            out_block[32*i +: 32] <= work[i] + init_s[i];
          end
          out_valid <= 1'b1;
          state     <= OUT;
        end

        OUT: begin
          // in_ready rises with the handshake, so the earliest new
          // acceptance is the edge after it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef CHACHA_ZEROIZE_EN
            out_block <= '0;
            for (int i = 0; i < 16; i++) begin
              work[i]   <= '0;
              init_s[i] <= '0;
            end
`endif
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_chacha_block_seq.sv
// tb/tb_chacha_block_seq.sv - directed self-checking bench for chacha_block_seq

module tb_chacha_block_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_valid8;
  logic         in_ready, in_ready8;
  logic [255:0] key;
  logic [31:0]  blk_ctr;
  logic [95:0]  nonce;
  logic         out_valid, out_valid8;
  logic         out_ready;
  logic [511:0] out_block, out_block8;
  logic         busy, busy8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chacha_block_seq #(.ROUNDS(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .blk_ctr   (blk_ctr),
    .nonce     (nonce),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  chacha_block_seq #(.ROUNDS(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .key       (key),
    .blk_ctr   (blk_ctr),
    .nonce     (nonce),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_block (out_block8),
    .busy      (busy8)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_rfc();
    key     = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
               32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
    blk_ctr = 32'h00000001;
    nonce   = {32'h00000000, 32'h4a000000, 32'h09000000};
  endtask

  // Called at the first negedge after the accepting edge; returns the number
  // of edges after acceptance at which out_valid was first seen.
  task automatic wait_lat(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_rfc(input string tag);
    chk({tag, "_w0"},  out_block[31:0],    32'he4e7f110);
    chk({tag, "_w1"},  out_block[63:32],   32'h15593bd1);
    chk({tag, "_w2"},  out_block[95:64],   32'h1fdd0f50);
    chk({tag, "_w3"},  out_block[127:96],  32'hc47120a3);
    chk({tag, "_w15"}, out_block[511:480], 32'h4e3c50a2);
  endtask

  initial begin
    int lat, lat8, cnt;
    logic [511:0] held;
    logic saw_valid;

    // ---- reset state
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    out_ready = 1'b0;
    key       = '0;
    blk_ctr   = '0;
    nonce     = '0;
    #1;
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_out_block", out_block, '0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready_clk", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // ---- all-zero vector on both widths: latency 21 / 9, word0 ade0b876
    in_valid  = 1'b1;
    in_valid8 = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    chk("zero_busy", busy, 1'b1);
    chk("zero_in_ready_busy", in_ready, 1'b0);
    lat = -1;
    lat8 = -1;
    cnt = 0;
    while ((lat < 0 || lat8 < 0) && cnt < 60) begin
      if (out_valid8 && lat8 < 0) lat8 = cnt;
      if (out_valid && lat < 0) lat = cnt;
      if (lat < 0 || lat8 < 0) begin
        @(negedge clk);
        cnt++;
      end
    end
    chk("zero_lat_r20", 32'(lat), 32'd21);
    chk("zero_lat_r8",  32'(lat8), 32'd9);
    chk("zero_w0", out_block[31:0], 32'hade0b876);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("zero_hs_out_valid",  out_valid,  1'b0);
    chk("zero_hs_out_valid8", out_valid8, 1'b0);

    // ---- RFC 8439 vector, in_valid pulse with another key during ROUND,
    //      inputs changed right after acceptance
    load_rfc();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    key = ~key;
    nonce = ~nonce;
    blk_ctr = 32'hdeadbeef;
    repeat (4) @(negedge clk);
    in_valid = 1'b1;
    key = {8{32'h5a5a5a5a}};
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("rfc_lat", 32'(lat + 5), 32'd21);
    chk_rfc("rfc");

    // ---- hold out_ready low for 10 cycles with a new request pending
    held = out_block;
    load_rfc();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_block", out_block, held);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 1'b0);
    chk("hs_in_ready", in_ready, 1'b1);
    chk("hs_busy", busy, 1'b0);
`ifdef CHACHA_ZEROIZE_EN
    chk("hs_zeroize", out_block, '0);
`else
    chk("hs_retain_w0", out_block[31:0], 32'he4e7f110);
`endif
    // back-to-back: pending request taken on the edge after the handshake
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_in_ready", in_ready, 1'b0);
    wait_lat(lat);
    chk("b2b_lat", 32'(lat), 32'd21);
    chk_rfc("b2b");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_hs_out_valid", out_valid, 1'b0);

    // ---- reset at round_cnt = 7
    @(negedge clk);
    load_rfc();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid || busy) saw_valid = 1'b1;
    end
    chk("abort_no_output", saw_valid, 1'b0);
    chk("abort_in_ready_after", in_ready, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_lat(lat);
    chk("after_abort_lat", 32'(lat), 32'd21);
    chk_rfc("after_abort");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_abort_hs", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chacha_block_seq.md
CHACHA_BLOCK_SEQ -- requirements
Module: chacha_block_seq

Interface
REQ-001 The block SHALL have one parameter: ROUNDS, default 20, total ChaCha rounds; legal values are even, 2..30 (8, 12 and 20 are the supported variants).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  key/counter/nonce offered.
REQ-006 in_ready  output  1  block idle and able to accept a request.
REQ-007 key  input  256  key; word i = key[32i+31:32i], i = 0..7.
REQ-008 blk_ctr  input  32  block counter (state word 12).
REQ-009 nonce  input  96  nonce; word j = nonce[32j+31:32j] maps to state word 13+j.
REQ-010 out_valid  output  1  keystream block available.
REQ-011 out_ready  input  1  consumer accepts the block.
REQ-012 out_block  output  512  keystream; word i = out_block[32i+31:32i], i = 0..15.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have four states: IDLE, ROUND, FINAL, OUT.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with in_valid=1 and in_ready=1, and in_valid is ignored in every other state.
REQ-016 On acceptance, the block SHALL load working and initial state: words 0..3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; words 4..11 = key words 0..7; word 12 = blk_ctr; words 13..15 = nonce words 0..2; round_cnt = 0; next state ROUND.
REQ-017 Each ROUND cycle SHALL apply four parallel quarter rounds (a+=b, d^=a, d<<<=16; c+=d, b^=c, b<<<=12; a+=b, d^=a, d<<<=8; c+=d, b^=c, b<<<=7), all adds mod 2^32.
REQ-018 When round_cnt is even, a ROUND cycle SHALL apply a column round on words (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
REQ-019 When round_cnt is odd, a ROUND cycle SHALL apply a diagonal round on words (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
REQ-020 round_cnt SHALL increment once per ROUND cycle; the cycle with round_cnt = ROUNDS-1 SHALL transition to FINAL.
REQ-021 FINAL SHALL register out_block word i = working word i + initial word i (mod 2^32), set out_valid = 1 and transition to OUT.
REQ-022 out_valid SHALL rise exactly ROUNDS+1 clock edges after the accepting edge (21 for ROUNDS = 20).
REQ-023 In OUT, out_valid and out_block SHALL hold stable until an edge with out_ready = 1; on that edge out_valid clears and the next state is IDLE.
REQ-024 A new request SHALL NOT be accepted on the same edge as the output handshake; the earliest acceptance is the following edge.
REQ-025 out_ready SHALL be ignored while out_valid = 0.
REQ-026 Inputs key, blk_ctr and nonce SHALL be sampled only on the accepting edge; later changes SHALL NOT affect the result.

Reset
REQ-027 While rst_n = 0, the block SHALL force: state = IDLE, round_cnt = 0, out_valid = 0, busy = 0, working/initial state = 0, out_block = 0.
REQ-028 While rst_n = 0, in_ready SHALL be 0; it SHALL read 1 from the first clock edge after rst_n deasserts.
REQ-029 Reset asserted mid-operation (ROUND, FINAL or OUT) SHALL abort the operation; the block SHALL NOT produce any partial output afterwards.

Configuration
REQ-030 With macro CHACHA_ZEROIZE_EN defined, on the output-handshake edge the block SHALL clear working state, initial state and out_block to 0.
REQ-031 Without CHACHA_ZEROIZE_EN, out_block SHALL retain the last block after the handshake, and internal state is don't-care.

Verification
REQ-032 RFC 8439 2.3.2 vector: key bytes 00..1f (word4 = 0x03020100), blk_ctr = 1, nonce words 0x09000000, 0x4a000000, 0x00000000 -> out_block words 0..3 = e4e7f110, 15593bd1, 1fdd0f50, c47120a3 and word 15 = 4e3c50a2, with out_valid rising 21 edges after acceptance.
REQ-033 All-zero key/nonce with blk_ctr = 0 -> out_block word 0 = 0xade0b876; with ROUNDS = 8, out_valid rises 9 edges after acceptance.
REQ-034 Hold out_ready = 0 for 10 cycles after out_valid -> out_block stable and in_ready = 0 throughout; on the edge out_ready = 1, out_valid = 0; in_ready = 1 on the next cycle.
REQ-035 Pulse in_valid with different key during ROUND -> ignored, result equals the first vector; back-to-back requests -> second accepted one edge after the handshake.
REQ-036 Assert rst_n = 0 at round_cnt = 7 -> out_valid = 0, busy = 0 immediately; a fresh request after reset yields the REQ-032 result.
REQ-037 With CHACHA_ZEROIZE_EN, out_block = 0 on the cycle after the handshake; without it, out_block still equals e4e7f110... after the handshake.
